// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: mode encoding and counter width.
package act_pkg;

    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_CLIP   = 2'd2,
        ACT_BYPASS = 2'd3
    } act_mode_e;

    localparam int ZeroCountWidth = 32;

endpackage

// File: rtl/act_elem.sv
// Per-element activation: ReLU / leaky / clip / bypass, then signed saturation to OutputWidth.
// neg_zero flags an element that was negative and forced to zero.
module act_elem
    import act_pkg::*;
#(
    parameter int InputWidth  = 8,
    parameter int OutputWidth = InputWidth,
    parameter int LeakShift   = 3,
    parameter int ClipMax     = 2**(OutputWidth-1)-1
) (
    input  logic [InputWidth-1:0]  x,
    input  act_mode_e              mode,
    output logic [OutputWidth-1:0] y,
    output logic                   neg_zero
);

    // One guard bit above the wider of the two widths keeps every intermediate exact.
    localparam int WW = ((InputWidth > OutputWidth) ? InputWidth : OutputWidth) + 1;
    localparam logic signed [WW-1:0] OMAX = WW'((2**(OutputWidth-1)) - 1);
    localparam logic signed [WW-1:0] OMIN = ~OMAX;
    localparam logic signed [WW-1:0] CMAX = WW'(ClipMax);

    logic signed [WW-1:0] xe;
    logic signed [WW-1:0] r;
    logic                 neg;

    assign xe  = {{(WW-InputWidth){x[InputWidth-1]}}, x};
    assign neg = x[InputWidth-1];

    always_comb begin
        r = xe;
        case (mode)
            ACT_RELU:   r = neg ? '0 : xe;
            ACT_LEAKY:  r = neg ? (xe >>> LeakShift) : xe;
            ACT_CLIP:   r = neg ? '0 : ((xe > CMAX) ? CMAX : xe);
            default:    r = xe;
        endcase
    end

    always_comb begin
        if (r > OMAX) begin
            y = OMAX[OutputWidth-1:0];
        end else if (r < OMIN) begin
            y = OMIN[OutputWidth-1:0];
        end else begin
            y = r[OutputWidth-1:0];
        end
    end

    assign neg_zero = neg & ((mode == ACT_RELU) | (mode == ACT_CLIP));

endmodule

// File: rtl/activation_pipe.sv
// Two-stage elastic activation pipeline (S1 compute register, S2 output register)
// with a saturating count of negative elements zeroed at the output handshake.
module activation_pipe
    import act_pkg::*;
#(
    parameter int InputWidth  = 8,
    parameter int OutputWidth = InputWidth,
    parameter int Channels    = 1,
    parameter int LeakShift   = 3,
    parameter int ClipMax     = 2**(OutputWidth-1)-1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [Channels*InputWidth-1:0]  data_i,
    input  logic [1:0]                      mode_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [Channels*OutputWidth-1:0] data_o,
    input  logic                            clear_i,
    output logic [ZeroCountWidth-1:0]       zero_count_o
);

    localparam int ZW = $clog2(Channels + 1);

    logic [Channels*OutputWidth-1:0] act_d;
    logic [Channels*OutputWidth-1:0] s1_data;
    logic [Channels*OutputWidth-1:0] s2_data;
    logic [Channels-1:0]             zf;
    logic [ZW-1:0]                   zsum;
    logic [ZW-1:0]                   s1_zeros;
    logic [ZW-1:0]                   s2_zeros;
    logic                            s1_valid;
    logic                            s2_valid;
    logic                            s1_adv;
    logic                            s2_adv;
    logic                            out_hs;
    logic [ZeroCountWidth:0]         cnt_sum;
    logic [ZeroCountWidth-1:0]       cnt_next;
    logic [ZeroCountWidth-1:0]       zero_count_q;

    // Mode is consumed here, at acceptance, so later mode_i changes cannot reach stored beats.
    for (genvar c = 0; c < Channels; c++) begin : g_ch
        act_elem #(
            .InputWidth  (InputWidth),
            .OutputWidth (OutputWidth),
            .LeakShift   (LeakShift),
            .ClipMax     (ClipMax)
        ) u_elem (
            .x        (data_i[c*InputWidth +: InputWidth]),
            .mode     (act_mode_e'(mode_i)),
            .y        (act_d[c*OutputWidth +: OutputWidth]),
            .neg_zero (zf[c])
        );
    end

    always_comb begin
        zsum = '0;
        for (int c = 0; c < Channels; c++) begin
            zsum = zsum + ZW'(zf[c]);
        end
    end

    assign s2_adv  = ~s2_valid | ready_i;
    assign s1_adv  = ~s1_valid | s2_adv;
    assign ready_o = s1_adv;
    assign out_hs  = s2_valid & ready_i;
    assign valid_o = s2_valid;
    assign data_o  = s2_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_data  <= '0;
            s2_data  <= '0;
            s1_zeros <= '0;
            s2_zeros <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= valid_i;
                if (valid_i) begin
                    s1_data  <= act_d;
                    s1_zeros <= zsum;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data  <= s1_data;
                    s2_zeros <= s1_zeros;
                end
            end
        end
    end

    assign cnt_sum  = {1'b0, zero_count_q} + (ZeroCountWidth+1)'(s2_zeros);
    assign cnt_next = cnt_sum[ZeroCountWidth] ? '1 : cnt_sum[ZeroCountWidth-1:0];

    // A clear that coincides with an output handshake keeps that beat's contribution.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            zero_count_q <= '0;
        end else if (out_hs) begin
            zero_count_q <= clear_i ? ZeroCountWidth'(s2_zeros) : cnt_next;
        end else if (clear_i) begin
            zero_count_q <= '0;
        end
    end

    assign zero_count_o = zero_count_q;

endmodule

// File: doc/activation_pipe.md
ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 SHALL have parameter InputWidth, default 8, signed input element width in bits (>=2).
REQ-002 SHALL have parameter OutputWidth, default InputWidth, signed output element width in bits (>=2).
REQ-003 SHALL have parameter Channels, default 1, number of parallel elements per beat.
REQ-004 SHALL have parameter LeakShift, default 3, arithmetic right-shift amount for leaky mode (0..InputWidth-1).
REQ-005 SHALL have parameter ClipMax, default 2**(OutputWidth-1)-1, upper clamp for clipped mode (1..2**(OutputWidth-1)-1).
REQ-006 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port valid_i, input, 1, input beat valid.
REQ-009 SHALL have port ready_o, output, 1, block accepts input beat.
REQ-010 SHALL have port data_i, input, Channels x InputWidth, signed elements.
REQ-011 SHALL have port mode_i, input, 2, activation mode, qualified by valid_i.
REQ-012 SHALL have port valid_o, output, 1, output beat valid.
REQ-013 SHALL have port ready_i, input, 1, downstream accepts output beat.
REQ-014 SHALL have port data_o, output, Channels x OutputWidth, signed elements.
REQ-015 SHALL have port clear_i, input, 1, synchronous clear of zero_count_o.
REQ-016 SHALL have port zero_count_o, output, 32, count of elements output as zero from negative input.

Function
REQ-017 SHALL transfer an input beat when valid_i & ready_o, an output beat when valid_o & ready_i.
REQ-018 SHALL apply per element by mode captured with the beat: 0 ReLU (x<0 -> 0 else x); 1 leaky (x<0 -> x>>>LeakShift, rounding toward -inf, else x); 2 clipped (x<0 -> 0, x>ClipMax -> ClipMax, else x); 3 bypass (x).
REQ-019 SHALL signed-saturate every mode result to OutputWidth (max 2**(OutputWidth-1)-1, min -2**(OutputWidth-1)); sign-extend when OutputWidth > InputWidth.
REQ-020 SHALL be a two-stage elastic pipeline (S1 compute register, S2 output register), latency exactly 2 cycles from input handshake to valid_o with ready_i held high.
REQ-021 SHALL sustain one beat per cycle with ready_i high; no bubbles inserted.
REQ-022 SHALL advance each stage when its valid is low or the next stage accepts; ready_o = ~S1_valid | S2 advances (combinational from ready_i permitted).
REQ-023 SHALL hold data_o and valid_o stable while valid_o & ~ready_i; no beat dropped or duplicated under any ready_i pattern.
REQ-024 SHALL increment zero_count_o by the number of elements in an output beat that came from negative input and are 0 (modes 0 and 2), at the output handshake only.
REQ-025 SHALL saturate zero_count_o at 2**32-1 (no wrap).
REQ-026 SHALL, on clear_i with a simultaneous counted handshake, load the beat's count instead of 0.
REQ-027 SHALL never let mode_i changes affect beats already accepted.

Reset
REQ-028 SHALL on rst_i asynchronously set S1/S2 valid to 0, valid_o 0, zero_count_o 0; data registers reset to 0.
REQ-029 SHALL drive ready_o 1 in the first cycle after rst_i deasserts; reset mid-stream discards in-flight beats.

Structure
REQ-030 SHALL place mode encoding (enum act_mode_e: ACT_RELU, ACT_LEAKY, ACT_CLIP, ACT_BYPASS) in shared package act_pkg.
REQ-031 SHALL implement per-element arithmetic in one combinational sub-module act_elem, instantiated Channels times.
REQ-032 SHALL keep handshake/pipeline and counter logic in activation_pipe.

Verification
REQ-033 SHALL cover: IW=OW=8, mode 0, data {-5,7} -> data_o {0,7} two cycles later, zero_count_o 1.
REQ-034 SHALL cover: mode 1, LeakShift 3, x=-20 -> -3; x=-1 -> -1; x=100 -> 100.
REQ-035 SHALL cover: mode 2, ClipMax 6, inputs {-128,3,6,127} -> {0,3,6,6}; IW=8,OW=4 mode 3 x=100 -> 7, x=-100 -> -8.
REQ-036 SHALL cover: 1000 random beats, random valid_i and ready_i (50%) -> output sequence equals reference model in order, no loss or duplication, data_o stable while stalled.
REQ-037 SHALL cover: clear_i coincident with output handshake carrying 2 zeroed elements -> zero_count_o 2; counter preloaded 2**32-2 plus 3 zeros -> 2**32-1.
REQ-038 SHALL cover: rst_i asserted with two beats in flight -> valid_o 0 immediately, zero_count_o 0, ready_o 1 after release.
